// File: rtl/soc_node_err_slv_if.sv
// AXI4 bus interface (AW/W/B/AR/R channels) used by the error slave.
// Carries the subset of AXI4 fields that the interconnect ports use.
interface AXI_BUS #(
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned AXI_DW = 64,
  parameter int unsigned AXI_IW = 8,
  parameter int unsigned AXI_UW = 6
);
  logic [AXI_IW-1:0]   aw_id;
  logic [AXI_AW-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [AXI_UW-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [AXI_DW-1:0]   w_data;
  logic [AXI_DW/8-1:0] w_strb;
  logic                w_last;
  logic [AXI_UW-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [AXI_IW-1:0]   b_id;
  logic [1:0]          b_resp;
  logic [AXI_UW-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [AXI_IW-1:0]   ar_id;
  logic [AXI_AW-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [AXI_UW-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [AXI_IW-1:0]   r_id;
  logic [AXI_DW-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [AXI_UW-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_user, ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input aw_id, aw_addr, aw_len, aw_user, aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/soc_node_err_slv.sv
// AXI4 default responder: accepts every transaction, drains write bursts, returns full-length
// read bursts, answers everything with an error response and counts completed transactions.
module soc_node_err_slv #(
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned AXI_DW = 64,
  parameter int unsigned AXI_IW = 8,
  parameter int unsigned AXI_UW = 6,
  parameter logic [1:0]  RESP   = 2'b11,
  parameter logic [63:0] RDATA  = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  AXI_BUS.Slave       slv,
  input  logic        clr_cnt_i,
  output logic [15:0] err_cnt_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  function automatic logic [AXI_DW-1:0] rdata_pattern();
    logic [AXI_DW-1:0] p;
    for (int unsigned i = 0; i < AXI_DW; i++) begin
      p[i] = RDATA[i % 64];
    end
    return p;
  endfunction

  localparam logic [AXI_DW-1:0] RDataRep = rdata_pattern();

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [AXI_IW-1:0] b_id_q, b_id_d;
  logic [AXI_IW-1:0] r_id_q, r_id_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic r_last_int;
  logic b_hs, r_done;

  // Last-beat compare uses the pre-increment count, so len=255 never wraps.
  assign r_last_int = (r_state_q == RData) && (r_cnt_q == r_len_q);
  assign b_hs       = (w_state_q == WResp) && slv.b_ready;
  assign r_done     = r_last_int && slv.r_ready;

  always_comb begin
    w_state_d = w_state_q;
    b_id_d    = b_id_q;
    unique case (w_state_q)
      WIdle: begin
        if (slv.aw_valid) begin
          b_id_d    = slv.aw_id;
          w_state_d = WData;
        end
      end
      WData: begin
        if (slv.w_valid && slv.w_last) w_state_d = WResp;
      end
      WResp: begin
        if (slv.b_ready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      RIdle: begin
        if (slv.ar_valid) begin
          r_id_d    = slv.ar_id;
          r_len_d   = slv.ar_len;
          r_cnt_d   = 8'd0;
          r_state_d = RData;
        end
      end
      RData: begin
        if (slv.r_ready) begin
          if (r_last_int) r_state_d = RIdle;
          else            r_cnt_d   = r_cnt_q + 8'd1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    logic [1:0]  inc;
    logic [16:0] sum;
    inc = {1'b0, b_hs} + {1'b0, r_done};
    sum = {1'b0, err_cnt_q} + {15'd0, inc};
    if (clr_cnt_i)    err_cnt_d = 16'd0;
    else if (sum[16]) err_cnt_d = 16'hFFFF;
    else              err_cnt_d = sum[15:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      b_id_q    <= '0;
      r_id_q    <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      err_cnt_q <= 16'd0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      b_id_q    <= b_id_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign slv.aw_ready = (w_state_q == WIdle);
  assign slv.w_ready  = (w_state_q == WData);
  assign slv.b_valid  = (w_state_q == WResp);
  assign slv.b_id     = b_id_q;
  assign slv.b_resp   = RESP;
  assign slv.b_user   = '0;

  assign slv.ar_ready = (r_state_q == RIdle);
  assign slv.r_valid  = (r_state_q == RData);
  assign slv.r_id     = r_id_q;
  assign slv.r_data   = RDataRep;
  assign slv.r_resp   = RESP;
  assign slv.r_last   = r_last_int;
  assign slv.r_user   = '0;

  assign err_cnt_o = err_cnt_q;
  assign busy_o    = (w_state_q != WIdle) || (r_state_q != RIdle);

endmodule

// File: tb/tb_soc_node_err_slv.sv
// Bench for soc_node_err_slv: cycle tables for the basic flows plus hand-written
// sequences for backpressure, saturation and asynchronous reset mid-burst.
module tb_soc_node_err_slv;

  localparam logic [63:0] ExpData = 64'hBADC_AB1E_BADC_AB1E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] err_cnt;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_AW(32), .AXI_DW(64), .AXI_IW(8), .AXI_UW(6)) bus ();

  soc_node_err_slv dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv       (bus),
    .clr_cnt_i (clr),
    .err_cnt_o (err_cnt),
    .busy_o    (busy)
  );

  // Inputs for one cycle, and outputs expected while those inputs are applied.
  typedef struct {
    logic awv; logic [7:0] awid; logic wv; logic wl; logic br;
    logic arv; logic [7:0] arid; logic [7:0] arlen; logic rr; logic clr;
    logic e_awr; logic e_wr; logic e_bv; logic [7:0] e_bid;
    logic e_arr; logic e_rv; logic e_rl; logic [7:0] e_rid;
    logic e_busy; logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[22];
  vec_t sats[9];

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.aw_valid = v.awv; bus.aw_id = v.awid; bus.aw_len = 8'd0;
    bus.w_valid  = v.wv;  bus.w_last = v.wl;  bus.b_ready = v.br;
    bus.ar_valid = v.arv; bus.ar_id = v.arid; bus.ar_len = v.arlen;
    bus.r_ready  = v.rr;  clr = v.clr;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    chk("aw_ready", idx, 64'(bus.aw_ready), 64'(v.e_awr));
    chk("w_ready",  idx, 64'(bus.w_ready),  64'(v.e_wr));
    chk("b_valid",  idx, 64'(bus.b_valid),  64'(v.e_bv));
    if (v.e_bv) begin
      chk("b_id",   idx, 64'(bus.b_id),   64'(v.e_bid));
      chk("b_resp", idx, 64'(bus.b_resp), 64'(2'b11));
    end
    chk("ar_ready", idx, 64'(bus.ar_ready), 64'(v.e_arr));
    chk("r_valid",  idx, 64'(bus.r_valid),  64'(v.e_rv));
    chk("r_last",   idx, 64'(bus.r_last),   64'(v.e_rl));
    if (v.e_rv) begin
      chk("r_id",   idx, 64'(bus.r_id),   64'(v.e_rid));
      chk("r_data", idx, bus.r_data,      ExpData);
      chk("r_resp", idx, 64'(bus.r_resp), 64'(2'b11));
    end
    chk("busy",    idx, 64'(busy),    64'(v.e_busy));
    chk("err_cnt", idx, 64'(err_cnt), 64'(v.e_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, wb, bcnt;
    vec_t v;

    // awv awid wv wl br arv arid arlen rr clr | awr wr bv bid arr rv rl rid busy cnt
    vecs[0]  = '{1, 8'h05, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd0};
    vecs[1]  = '{0, 8'h00, 1, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 16'd0};
    vecs[2]  = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 8'd0, 0, 0, 0, 0, 1, 8'h05, 1, 0, 0, 8'h00, 1, 16'd0};
    vecs[3]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd1};
    vecs[4]  = '{0, 8'h00, 0, 0, 0, 1, 8'h03, 8'd3, 1, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd1};
    vecs[5]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h03, 1, 16'd1};
    vecs[6]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h03, 1, 16'd1};
    vecs[7]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h03, 1, 16'd1};
    vecs[8]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h03, 1, 16'd1};
    vecs[9]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd2};
    // W presented before AW must stall.
    vecs[10] = '{0, 8'h00, 1, 1, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd2};
    vecs[11] = '{1, 8'h0A, 1, 1, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd2};
    vecs[12] = '{0, 8'h00, 1, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 16'd2};
    vecs[13] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 0, 0, 1, 8'h0A, 1, 0, 0, 8'h00, 1, 16'd2};
    vecs[14] = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 8'd0, 0, 0, 0, 0, 1, 8'h0A, 1, 0, 0, 8'h00, 1, 16'd2};
    vecs[15] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd3};
    // Write and read complete on the same edge.
    vecs[16] = '{1, 8'h01, 0, 0, 0, 1, 8'h02, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd3};
    vecs[17] = '{0, 8'h00, 1, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 1, 8'h02, 1, 16'd3};
    vecs[18] = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 8'd0, 1, 0, 0, 0, 1, 8'h01, 0, 1, 1, 8'h02, 1, 16'd3};
    vecs[19] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd5};
    vecs[20] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 1, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd5};
    vecs[21] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd0};

    // Saturation from 16'hFFFE, then clear racing a double completion.
    sats[0] = '{1, 8'h01, 0, 0, 0, 1, 8'h02, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'hFFFE};
    sats[1] = '{0, 8'h00, 1, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 1, 8'h02, 1, 16'hFFFE};
    sats[2] = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 8'd0, 1, 0, 0, 0, 1, 8'h01, 0, 1, 1, 8'h02, 1, 16'hFFFE};
    sats[3] = '{0, 8'h00, 0, 0, 0, 1, 8'h02, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'hFFFF};
    sats[4] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h02, 1, 16'hFFFF};
    sats[5] = '{1, 8'h01, 0, 0, 0, 1, 8'h02, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'hFFFF};
    sats[6] = '{0, 8'h00, 1, 1, 0, 0, 8'h00, 8'd0, 0, 0, 0, 1, 0, 8'h00, 0, 1, 1, 8'h02, 1, 16'hFFFF};
    sats[7] = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 8'd0, 1, 1, 0, 0, 1, 8'h01, 0, 1, 1, 8'h02, 1, 16'hFFFF};
    sats[8] = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 8'd0, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 16'd0};

    v = vecs[21];
    drive(v);
    bus.aw_addr = '0; bus.aw_user = '0; bus.w_data = '0; bus.w_strb = '0; bus.w_user = '0;
    bus.ar_addr = '0; bus.ar_user = '0;

    // Reset state.
    @(negedge clk);
    chk("rst_aw_ready", 0, 64'(bus.aw_ready), 64'd1);
    chk("rst_ar_ready", 0, 64'(bus.ar_ready), 64'd1);
    chk("rst_w_ready",  0, 64'(bus.w_ready),  64'd0);
    chk("rst_b_valid",  0, 64'(bus.b_valid),  64'd0);
    chk("rst_r_valid",  0, 64'(bus.r_valid),  64'd0);
    chk("rst_r_last",   0, 64'(bus.r_last),   64'd0);
    chk("rst_err_cnt",  0, 64'(err_cnt),      64'd0);
    chk("rst_busy",     0, 64'(busy),         64'd0);
    #2 rst = 1'b0;

    for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

    // len=255 read under random r_ready.
    @(posedge clk); #1;
    bus.ar_valid = 1'b1; bus.ar_id = 8'h07; bus.ar_len = 8'd255;
    @(negedge clk);
    chk("bp_ar_ready", 0, 64'(bus.ar_ready), 64'd1);
    beats = 0;
    for (int c = 0; c < 3000 && beats < 256; c++) begin
      @(posedge clk); #1;
      bus.ar_valid = 1'b0;
      bus.r_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_r_valid", beats, 64'(bus.r_valid), 64'd1);
      if (!bus.r_valid) break;
      chk("bp_r_last", beats, 64'(bus.r_last), 64'(beats == 255));
      chk("bp_r_id",   beats, 64'(bus.r_id),   64'h07);
      chk("bp_r_data", beats, bus.r_data,      ExpData);
      if (bus.r_ready) beats++;
    end
    chk("bp_r_beats", 0, 64'(beats), 64'd256);
    @(posedge clk); #1;
    bus.r_ready = 1'b0;
    @(negedge clk);
    chk("bp_r_done_valid", 0, 64'(bus.r_valid),  64'd0);
    chk("bp_r_done_ready", 0, 64'(bus.ar_ready), 64'd1);

    // 8-beat write with gappy W and random b_ready.
    @(posedge clk); #1;
    bus.aw_valid = 1'b1; bus.aw_id = 8'h09; bus.aw_len = 8'd7;
    @(negedge clk);
    chk("bw_aw_ready", 0, 64'(bus.aw_ready), 64'd1);
    wb = 0;
    for (int c = 0; c < 200 && wb < 8; c++) begin
      @(posedge clk); #1;
      bus.aw_valid = 1'b0;
      bus.w_valid  = 1'($urandom_range(0, 1));
      bus.w_last   = (wb == 7);
      @(negedge clk);
      chk("bw_w_ready", wb, 64'(bus.w_ready), 64'd1);
      chk("bw_b_early", wb, 64'(bus.b_valid), 64'd0);
      if (!bus.w_ready) break;
      if (bus.w_valid) wb++;
    end
    chk("bw_w_beats", 0, 64'(wb), 64'd8);
    bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      bus.w_valid = 1'b0; bus.w_last = 1'b0;
      bus.b_ready = (c >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bcnt == 0) begin
        chk("bw_b_valid", c, 64'(bus.b_valid), 64'd1);
        chk("bw_b_id",    c, 64'(bus.b_id),    64'h09);
        if (bus.b_valid && bus.b_ready) bcnt++;
      end else begin
        chk("bw_b_extra", c, 64'(bus.b_valid), 64'd0);
        if (bus.b_valid && bus.b_ready) bcnt++;
      end
    end
    chk("bw_b_count", 0, 64'(bcnt), 64'd1);
    chk("bw_err_cnt", 0, 64'(err_cnt), 64'd2);
    @(posedge clk); #1;
    bus.b_ready = 1'b0;

    // Preload the counter near saturation.
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    for (int i = 0; i < 9; i++) run_vec(sats[i], 100 + i);

    // Asynchronous reset on beat 2 of a len=7 read.
    v = vecs[21];
    v.arv = 1'b1; v.arid = 8'h04; v.arlen = 8'd7; v.rr = 1'b1;
    v.e_cnt = 16'd0;
    run_vec(v, 200);
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    @(negedge clk);
    chk("mr_beat1_valid", 0, 64'(bus.r_valid), 64'd1);
    @(posedge clk); #1;
    chk("mr_beat2_valid", 0, 64'(bus.r_valid), 64'd1);
    chk("mr_beat2_last",  0, 64'(bus.r_last),  64'd0);
    rst = 1'b1;
    #1;
    chk("mr_r_valid",  0, 64'(bus.r_valid),  64'd0);
    chk("mr_busy",     0, 64'(busy),         64'd0);
    chk("mr_ar_ready", 0, 64'(bus.ar_ready), 64'd1);
    chk("mr_r_last",   0, 64'(bus.r_last),   64'd0);
    chk("mr_err_cnt",  0, 64'(err_cnt),      64'd0);
    bus.r_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    v = vecs[21];
    v.arv = 1'b1; v.arid = 8'h06; v.arlen = 8'd1; v.rr = 1'b1;
    run_vec(v, 300);
    v = vecs[5]; v.e_rid = 8'h06; v.e_cnt = 16'd0;
    run_vec(v, 301);
    v = vecs[8]; v.e_rid = 8'h06; v.e_cnt = 16'd0;
    run_vec(v, 302);
    v = vecs[21]; v.e_cnt = 16'd1;
    run_vec(v, 303);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
